// File: rtl/norm_sched.sv
// norm_sched: round-robin shared normalizer. The granted 12-bit value is
// shifted so its leading one lands at bit 10; a leading one at bit 11 is
// shifted right by one instead. Default build shifts one bit per cycle.
// Define NORM_FASTSHIFT_EN to normalize in a single SHIFT cycle using a
// leading-one encoder and barrel shifter (results identical).
module norm_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*12-1:0] val,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       out_mant,
  output logic [4:0]        out_shift,
  output logic              out_zero,
  output logic [IDW-1:0]    out_id
);

  localparam int unsigned N = NREQ;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick;
  logic           found;
  int unsigned    pick_i;
  int unsigned    cand;
  logic [11:0]    work;
  logic [11:0]    sel_val;
`ifdef NORM_FASTSHIFT_EN
  logic [3:0]     lead_sh;
`else
  logic [3:0]     count;
`endif

  // Round-robin search starting one past the last served requester
  always_comb begin
    found  = 1'b0;
    pick_i = 0;
    cand   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && (((req >> cand) & NREQ'(1)) != '0)) begin
        found  = 1'b1;
        pick_i = cand;
      end
    end
  end

  assign pick    = IDW'(pick_i);
  assign sel_val = 12'(val >> (12 * pick_i));
  assign busy    = (state != IDLE);

`ifdef NORM_FASTSHIFT_EN
  // Leading-one position below bit 11 converted to a left-shift amount
  always_comb begin
    lead_sh = '0;
    for (int unsigned b = 0; b < 11; b++) begin
      if (work[b]) lead_sh = 4'(10 - b);
    end
  end
`endif

  // Arbitration, normalization and result handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDW'(NREQ - 1);
      work      <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
      out_id    <= '0;
`ifndef NORM_FASTSHIFT_EN
      count     <= '0;
`endif
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            work   <= sel_val;
            out_id <= pick;
            grant  <= NREQ'(1) << pick;
            state  <= SHIFT;
`ifndef NORM_FASTSHIFT_EN
            count  <= '0;
`endif
          end
        end
        SHIFT: begin
          if (work == '0) begin
            out_zero  <= 1'b1;
            out_shift <= '1;
            out_mant  <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (work[11]) begin
            out_zero  <= 1'b0;
            out_shift <= '1;
            out_mant  <= {1'b0, work[11:1]};
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef NORM_FASTSHIFT_EN
          end else begin
            out_zero  <= 1'b0;
            out_shift <= {1'b0, lead_sh};
            out_mant  <= work << lead_sh;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`else
          end else if (work[10]) begin
            out_zero  <= 1'b0;
            out_shift <= {1'b0, count};
            out_mant  <= work;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            work  <= work << 1;
            count <= count + 4'd1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= out_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
